// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle ARM datapath: fetch/decode/execute/memory/writeback
// sequencing, Moore mux-select decode, and a memory handshake timeout that halts the core.
module multicycle_ctrl_fsm #(
  parameter int WAIT_MAX = 15
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite,
  output logic [1:0] FlagW,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic       MemErr,
  output logic [3:0] State
);

  localparam int CNT_W = $clog2(WAIT_MAX) + 1;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXECR  = 4'd7,
    EXECI  = 4'd8,
    ALUWB  = 4'd9,
    BRANCH = 4'd10,
    HALT   = 4'd11
  } stateT;

  stateT            stateR;
  stateT            nextStateS;
  logic [CNT_W-1:0] waitCntR;
  logic             waitAtMaxS;
  logic             timeoutS;
  logic             retireS;
  logic             illegalS;
  logic [3:0]       cmdS;
  logic             cmpCmnS;

  // Only arithmetic commands produce meaningful carry/overflow.
  function automatic logic updatesCv(input logic [3:0] cmd);
    case (cmd)
      4'b0100, 4'b0010, 4'b1010, 4'b1011: updatesCv = 1'b1;
      default:                            updatesCv = 1'b0;
    endcase
  endfunction

  assign cmdS       = Funct[4:1];
  assign cmpCmnS    = (cmdS == 4'b1010) || (cmdS == 4'b1011);
  assign waitAtMaxS = (waitCntR == CNT_W'(WAIT_MAX - 1));
  assign State      = stateR;

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      stateR <= IDLE;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Next-state logic plus the retire/illegal/timeout events that feed the registered flags.
  always_comb begin
    nextStateS = stateR;
    timeoutS   = 1'b0;
    retireS    = 1'b0;
    illegalS   = 1'b0;
    case (stateR)
      IDLE:   nextStateS = FETCH;
      FETCH: begin
        if (MemReady) begin
          nextStateS = DECODE;
        end else if (waitAtMaxS) begin
          nextStateS = HALT;
          timeoutS   = 1'b1;
        end else begin
          nextStateS = FETCH;
        end
      end
      DECODE: begin
        case (Op)
          2'b00:   nextStateS = Funct[5] ? EXECI : EXECR;
          2'b01:   nextStateS = MEMADR;
          2'b10:   nextStateS = BRANCH;
          default: begin
            nextStateS = FETCH;
            illegalS   = 1'b1;
            retireS    = 1'b1;
          end
        endcase
      end
      MEMADR: nextStateS = Funct[0] ? MEMRD : MEMWR;
      MEMRD: begin
        if (MemReady) begin
          nextStateS = MEMWB;
        end else if (waitAtMaxS) begin
          nextStateS = HALT;
          timeoutS   = 1'b1;
        end else begin
          nextStateS = MEMRD;
        end
      end
      MEMWB: begin
        nextStateS = FETCH;
        retireS    = 1'b1;
      end
      MEMWR: begin
        if (MemReady) begin
          nextStateS = FETCH;
          retireS    = 1'b1;
        end else if (waitAtMaxS) begin
          nextStateS = HALT;
          timeoutS   = 1'b1;
        end else begin
          nextStateS = MEMWR;
        end
      end
      EXECR, EXECI: nextStateS = ALUWB;
      ALUWB, BRANCH: begin
        nextStateS = FETCH;
        retireS    = 1'b1;
      end
      HALT:    nextStateS = HALT;
      default: nextStateS = IDLE;
    endcase
  end

  // Moore decode of the datapath controls; IRWrite/NextPC follow MemReady only in FETCH.
  always_comb begin
    MemReq    = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    PCS       = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    NoWrite   = 1'b0;
    FlagW     = 2'b00;
    case (stateR)
      FETCH: begin
        MemReq    = 1'b1;
        IRWrite   = MemReady;
        NextPC    = MemReady;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        PCS       = (Rd == 4'd15);
      end
      MEMWR: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR, EXECI: begin
        ALUSrcB = (stateR == EXECI) ? 2'b01 : 2'b00;
        ALUOp   = 1'b1;
        FlagW   = {Funct[0], Funct[0] & updatesCv(cmdS)};
        NoWrite = cmpCmnS;
      end
      ALUWB: begin
        RegW    = 1'b1;
        PCS     = (Rd == 4'd15);
        NoWrite = cmpCmnS;
      end
      BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCS       = 1'b1;
      end
      default: begin
        MemReq = 1'b0;
      end
    endcase
  end

  // Memory wait counter: counts stalled request cycles, restarts on every state change.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      waitCntR <= {CNT_W{1'b0}};
    end else if (nextStateS != stateR) begin
      waitCntR <= {CNT_W{1'b0}};
    end else if (MemReq && !MemReady) begin
      waitCntR <= waitCntR + CNT_W'(1);
    end else begin
      waitCntR <= waitCntR;
    end
  end

  // Registered retire/illegal pulses and the sticky timeout flag.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      InstrDone <= 1'b0;
      IllegalOp <= 1'b0;
      MemErr    <= 1'b0;
    end else begin
      InstrDone <= retireS;
      IllegalOp <= illegalS;
      MemErr    <= MemErr | timeoutS;
    end
  end

endmodule
